tinyalu_core: RTL
=================

Name: tinyalu_core

Overview:
- Responder end of the TinyALU command protocol: the synthesizable ALU that the testbench BFM drives.
- Samples the start/op/A/B command on clk, executes it, and returns a 16-bit result with a one-cycle done pulse.
- Single-cycle ops: add, and, xor. Multi-cycle op: mul (configurable latency).
- Instantiated as the DUT beneath the BFM in the bench top.

Parameters:
- MUL_LATENCY, 3, cycles from accept edge to the edge on which done rises for mul; legal range 2..8.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- A  input  8  operand A, unsigned.
- B  input  8  operand B, unsigned.
- op  input  3  opcode: 000 no_op, 001 add, 010 and, 011 xor, 100 mul, 101..111 illegal.
- start  input  1  command request; held high by the initiator until done is seen.
- done  output  1  one-cycle completion pulse.
- result  output  16  result of the most recently completed op.
- err  output  1  one-cycle pulse on acceptance of an illegal opcode.

Behaviour:
- Reset (async assert, sync release):
  - done=0, err=0, result=16'h0000.
  - state=IDLE, armed=1.
  - Any in-flight op is discarded; no done is produced for it after release.
- States:
  - IDLE: waiting for a command.
  - BUSY: down-counter running.
  - WAIT_LOW: waiting for start to drop.
- Accept edge N: a rising edge with state=IDLE, armed=1, start=1. A, B and op are captured into internal registers. Input changes after N are ignored until the next accept.
- add/and/xor:
  - result is registered and done=1 at edge N+1.
  - done=0 at edge N+2.
  - State goes to WAIT_LOW at N+1.
- mul:
  - State goes to BUSY at N; the counter is loaded.
  - result=A*B and done=1 at edge N+MUL_LATENCY.
  - done=0 one edge later.
  - State goes to WAIT_LOW.
- no_op: no done, result unchanged, state goes to WAIT_LOW at N.
- Illegal opcode: treated as no_op except err=1 at edge N+1 for exactly one cycle.
- WAIT_LOW (armed=0): stays until start is sampled 0, then goes to IDLE with armed=1. This prevents a held start from retriggering.
  - If start is already 0 on the done edge, IDLE is reached at the next edge.
  - The earliest following accept is two edges after done rises.
- Arithmetic (all unsigned, zero-extended to 16 bits):
  - add: {7'b0, 9-bit sum including carry}.
  - and: {8'b0, A&B}.
  - xor: {8'b0, A^B}.
  - mul: full 16-bit product, no truncation.
- start deasserted while BUSY: no abort; the op completes, done still pulses, and the state goes to WAIT_LOW then IDLE.
- result holds its value between completions; it is never cleared except by reset.
- done and err are never high in the same cycle.
- done never asserts in IDLE without a preceding accept.

Test Plan:
- Reset, then add A=8'hFF, B=8'h01 -> done high for exactly 1 cycle at N+1, result=16'h0100.
- mul A=8'hFF, B=8'hFF with MUL_LATENCY=3 -> done at N+3 (not earlier), result=16'hFE01.
  - Rerun with MUL_LATENCY=5 -> done at N+5.
- and 8'hF0/8'h3C -> 16'h0030, then xor 8'hAA/8'hFF -> 16'h0055.
  - Issue back-to-back, start dropped after each done.
  - Between ops, result holds 16'h0030.
- Hold start=1 with op=add for 6 cycles after done -> exactly one done pulse; no re-execution until start goes low.
- Assert reset_n=0 two cycles into a mul (MUL_LATENCY=3) -> done=0 and result=0 immediately; no done after release.
  - A subsequent add 3+4 -> 16'h0007.
- op=3'b110 with start=1 -> err pulses at N+1, done stays 0, result unchanged.
  - op=no_op with start held 1 cycle -> no done and no err.

Source files
------------

// File: rtl/tinyalu_core.sv
// tinyalu_core: responder end of the TinyALU command protocol.
// Accepts a start/op/A/B command, executes add/and/xor in one cycle or mul in
// MUL_LATENCY cycles, and returns a 16-bit result with a one-cycle done pulse.
module tinyalu_core #(
    parameter int unsigned MUL_LATENCY = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  A,
    input  logic [7:0]  B,
    input  logic [2:0]  op,
    input  logic        start,
    output logic        done,
    output logic [15:0] result,
    output logic        err
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned RES_W = 16;

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_BUSY     = 2'd1,
        S_WAIT_LOW = 2'd2
    } state_t;

    state_t             r_state;
    logic               r_armed;
    logic [CNT_W-1:0]   r_count;
    logic [7:0]         r_a;
    logic [7:0]         r_b;
    logic [2:0]         r_op;
    logic               r_done;
    logic [RES_W-1:0]   r_result;
    logic               r_err;
    logic               r_err_pend;

    state_t             w_state;
    logic               w_armed;
    logic [CNT_W-1:0]   w_count;
    logic [7:0]         w_a;
    logic [7:0]         w_b;
    logic [2:0]         w_op;
    logic               w_done;
    logic [RES_W-1:0]   w_result;
    logic               w_err;
    logic               w_err_pend;
    logic [RES_W-1:0]   w_alu;
    logic [8:0]         w_sum;

    // Datapath on the captured operands; only consumed on the completion edge.
    always_comb begin
        w_sum = 9'(r_a) + 9'(r_b);
        case (r_op)
            OP_ADD:  w_alu = {7'b0, w_sum};
            OP_AND:  w_alu = {8'b0, r_a & r_b};
            OP_XOR:  w_alu = {8'b0, r_a ^ r_b};
            OP_MUL:  w_alu = RES_W'(r_a) * RES_W'(r_b);
            default: w_alu = r_result;
        endcase
    end

    // Next-state and next-output logic; single-cycle ops use BUSY with a count of 1.
    always_comb begin
        w_state    = r_state;
        w_armed    = r_armed;
        w_count    = r_count;
        w_a        = r_a;
        w_b        = r_b;
        w_op       = r_op;
        w_done     = 1'b0;
        w_result   = r_result;
        w_err      = r_err_pend;
        w_err_pend = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (r_armed && start) begin
                    w_a     = A;
                    w_b     = B;
                    w_op    = op;
                    w_armed = 1'b0;
                    case (op)
                        OP_ADD, OP_AND, OP_XOR: begin
                            w_state = S_BUSY;
                            w_count = CNT_W'(1);
                        end
                        OP_MUL: begin
                            w_state = S_BUSY;
                            w_count = CNT_W'(MUL_LATENCY);
                        end
                        OP_NOP: begin
                            w_state = S_WAIT_LOW;
                        end
                        default: begin
                            w_state    = S_WAIT_LOW;
                            w_err_pend = 1'b1;
                        end
                    endcase
                end
            end
            S_BUSY: begin
                if (r_count == CNT_W'(1)) begin
                    w_done   = 1'b1;
                    w_result = w_alu;
                    w_state  = S_WAIT_LOW;
                end else begin
                    w_count = r_count - CNT_W'(1);
                end
            end
            S_WAIT_LOW: begin
                if (!start) begin
                    w_state = S_IDLE;
                    w_armed = 1'b1;
                end
            end
            default: begin
                w_state = S_IDLE;
                w_armed = 1'b1;
            end
        endcase
    end

    // State and registered-output update; reset discards any in-flight op.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_armed    <= 1'b1;
            r_count    <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_op       <= OP_NOP;
            r_done     <= 1'b0;
            r_result   <= '0;
            r_err      <= 1'b0;
            r_err_pend <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_armed    <= w_armed;
            r_count    <= w_count;
            r_a        <= w_a;
            r_b        <= w_b;
            r_op       <= w_op;
            r_done     <= w_done;
            r_result   <= w_result;
            r_err      <= w_err;
            r_err_pend <= w_err_pend;
        end
    end

    assign done   = r_done;
    assign result = r_result;
    assign err    = r_err;

endmodule
